// File: rtl/hmac_sha256_stream.sv
// HMAC-SHA256 engine for multi-block messages. Drives an external SHA-256
// compression core through a valid/ready request/result handshake and caches
// the ipad/opad midstates so repeated requests under one key skip two
// compressions.
module hmac_sha256_stream #(
  parameter int unsigned MAX_BLOCKS = 2,
  parameter int unsigned LEN_W      = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      v_i,
  output logic                      r_o,
  input  logic [511:0]              key_i,
  input  logic [512*MAX_BLOCKS-1:0] msg_i,
  input  logic [LEN_W-1:0]          msg_len_i,
  input  logic                      reuse_key_i,
  output logic [255:0]              prf_o,
  output logic                      err_o,
  output logic                      v_o,
  input  logic                      r_i,
  output logic                      cmp_v_o,
  input  logic                      cmp_r_i,
  output logic [255:0]              cmp_state_o,
  output logic [511:0]              cmp_block_o,
  input  logic                      cmp_v_i,
  output logic                      cmp_r_o,
  input  logic [255:0]              cmp_digest_i
);

  localparam int unsigned MAX_MSG = 64*MAX_BLOCKS - 9;
  localparam int unsigned NBYTES  = 64*MAX_BLOCKS;
  localparam int unsigned MW      = 512*MAX_BLOCKS;
  localparam int unsigned BW      = $clog2(MAX_BLOCKS + 1);

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {IDLE, KI, KO, MSG, OUT, DONE} state_t;

  state_t          state, state_n;
  logic            wait_q, wait_n;   // 0: request phase, 1: waiting for result
  logic [511:0]    key_q;
  logic [MW-1:0]   pad_q;
  logic [BW-1:0]   nblk_q;
  logic [BW-1:0]   blk;
  logic [255:0]    istate, ostate, hstate;
  logic            cache_v;

  logic [MW-1:0]   pad_buf;
  logic [BW-1:0]   nblk_in;
  logic [63:0]     len_field;
  logic            len_err;
  logic [511:0]    cur_blk;
  logic            last_blk;
  logic            issuing;
  logic            res_fire;

  assign len_err   = 32'(msg_len_i) > MAX_MSG;
  assign nblk_in   = BW'((32'(msg_len_i) + 32'd72) >> 6);
  assign len_field = 64'd512 + (64'(msg_len_i) << 3);
  assign last_blk  = (blk == nblk_q - BW'(1));
  assign issuing   = (state == KI) || (state == KO) || (state == MSG) || (state == OUT);
  assign res_fire  = cmp_r_o && cmp_v_i;

  // Build the padded inner-message buffer from the raw inputs at accept time;
  // the length counts the ipad block, hence the extra 512 bits.
  always_comb begin
    pad_buf = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (b < 32'(msg_len_i))
        pad_buf[MW-1-8*b -: 8] = msg_i[MW-1-8*b -: 8];
      else if (b == 32'(msg_len_i))
        pad_buf[MW-1-8*b -: 8] = 8'h80;
    end
    for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
      if (k + 1 == 32'(nblk_in))
        pad_buf[MW-512*(k+1) +: 64] = len_field;
    end
  end

  // Select the current message block of the padded buffer.
  always_comb begin
    cur_blk = '0;
    for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
      if (32'(blk) == k)
        cur_blk = pad_q[MW-1-512*k -: 512];
    end
  end

  // State and handshake-phase register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      wait_q <= 1'b0;
    end else begin
      state  <= state_n;
      wait_q <= wait_n;
    end
  end

  // Next-state logic and all handshake/compression-request outputs.
  always_comb begin
    state_n     = state;
    wait_n      = wait_q;
    r_o         = 1'b0;
    v_o         = 1'b0;
    cmp_v_o     = 1'b0;
    cmp_r_o     = 1'b0;
    cmp_state_o = '0;
    cmp_block_o = '0;
    case (state)
      IDLE: begin
        r_o = !rst_i;
        if (v_i) begin
          wait_n = 1'b0;
          if (len_err)                     state_n = DONE;
          else if (reuse_key_i && cache_v) state_n = MSG;
          else                             state_n = KI;
        end
      end
      KI: begin
        cmp_state_o = H0;
        cmp_block_o = key_q ^ {64{8'h36}};
        if (wait_q && cmp_v_i) state_n = KO;
      end
      KO: begin
        cmp_state_o = H0;
        cmp_block_o = key_q ^ {64{8'h5c}};
        if (wait_q && cmp_v_i) state_n = MSG;
      end
      MSG: begin
        cmp_state_o = hstate;
        cmp_block_o = cur_blk;
        if (wait_q && cmp_v_i && last_blk) state_n = OUT;
      end
      OUT: begin
        cmp_state_o = ostate;
        cmp_block_o = {hstate, 1'b1, 191'b0, 64'd768};
        if (wait_q && cmp_v_i) state_n = DONE;
      end
      DONE: begin
        v_o = 1'b1;
        if (r_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (issuing) begin
      cmp_v_o = !wait_q;
      cmp_r_o = wait_q;
      if (!wait_q && cmp_r_i) wait_n = 1'b1;
      if (wait_q && cmp_v_i)  wait_n = 1'b0;
    end
  end

  // Request capture, chaining-state updates, midstate cache and result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_v <= 1'b0;
      prf_o   <= '0;
      err_o   <= 1'b0;
      key_q   <= '0;
      pad_q   <= '0;
      nblk_q  <= '0;
      blk     <= '0;
      istate  <= '0;
      ostate  <= '0;
      hstate  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v_i) begin
            key_q  <= key_i;
            pad_q  <= pad_buf;
            nblk_q <= nblk_in;
            blk    <= '0;
            prf_o  <= '0;
            err_o  <= len_err;
            if (reuse_key_i && cache_v) hstate <= istate;
          end
        end
        KI: if (res_fire) istate <= cmp_digest_i;
        KO: begin
          if (res_fire) begin
            ostate  <= cmp_digest_i;
            cache_v <= 1'b1;
            hstate  <= istate;
            blk     <= '0;
          end
        end
        MSG: begin
          if (res_fire) begin
            hstate <= cmp_digest_i;
            blk    <= blk + BW'(1);
          end
        end
        OUT: if (res_fire) prf_o <= cmp_digest_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_sha256_stream.sv
// Self-checking bench for hmac_sha256_stream: SHA-256 compression core model
// with optional random stalls, a software HMAC reference, and directed vectors.
`timescale 1ns/1ps
module tb_hmac_sha256_stream;

  localparam int unsigned MAX_BLOCKS = 2;
  localparam int unsigned LEN_W      = 7;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0]  JEFE_KEY = {32'h4a656665, 480'h0};
  localparam logic [1023:0] JEFE_MSG = {224'h7768617420646f2079612077616e7420666f72206e6f7468696e673f, 800'h0};
  localparam logic [255:0]  JEFE_PRF = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      v_i;
  logic                      r_o;
  logic [511:0]              key_i;
  logic [512*MAX_BLOCKS-1:0] msg_i;
  logic [LEN_W-1:0]          msg_len_i;
  logic                      reuse_key_i;
  logic [255:0]              prf_o;
  logic                      err_o;
  logic                      v_o;
  logic                      r_i;
  logic                      cmp_v_o;
  logic                      cmp_r_i;
  logic [255:0]              cmp_state_o;
  logic [511:0]              cmp_block_o;
  logic                      cmp_v_i;
  logic                      cmp_r_o;
  logic [255:0]              cmp_digest_i;

  always #5 clk_i = ~clk_i;

  hmac_sha256_stream #(.MAX_BLOCKS(MAX_BLOCKS), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .v_i(v_i), .r_o(r_o), .key_i(key_i), .msg_i(msg_i),
    .msg_len_i(msg_len_i), .reuse_key_i(reuse_key_i), .prf_o(prf_o), .err_o(err_o),
    .v_o(v_o), .r_i(r_i), .cmp_v_o(cmp_v_o), .cmp_r_i(cmp_r_i), .cmp_state_o(cmp_state_o),
    .cmp_block_o(cmp_block_o), .cmp_v_i(cmp_v_i), .cmp_r_o(cmp_r_o), .cmp_digest_i(cmp_digest_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // SHA-256 compression including the feed-forward addition.
  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KTAB[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + st[255:224], b + st[223:192], c + st[191:160], d + st[159:128],
            e + st[127:96],  f + st[95:64],   g + st[63:32],   h + st[31:0]};
  endfunction

  // Byte-oriented software HMAC-SHA256 reference.
  function automatic logic [255:0] hmac_ref(input logic [511:0] k, input logic [1023:0] m, input int len);
    logic [7:0]   pbuf [128];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [255:0] st, inner;
    int nb;
    nb = (len + 9 + 63) / 64;
    for (int b = 0; b < 128; b++)
      pbuf[b] = (b < len) ? m[1023-8*b -: 8] : ((b == len) ? 8'h80 : 8'h00);
    bits = 64'(512 + 8*len);
    for (int j = 0; j < 8; j++) pbuf[64*nb-8+j] = bits[63-8*j -: 8];
    st = sha_compress(H0, k ^ {64{8'h36}});
    for (int bn = 0; bn < nb; bn++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pbuf[64*bn+j];
      st = sha_compress(st, blk);
    end
    inner = st;
    st = sha_compress(H0, k ^ {64{8'h5c}});
    return sha_compress(st, {inner, 8'h80, 184'h0, 64'd768});
  endfunction

  // Compression core model; counters are monotonic and read as deltas.
  bit           stall = 1'b0;
  int           n_req = 0, n_h0 = 0, n_overlap = 0, n_vcyc = 0, n_unstable = 0;
  logic [511:0] bh1, bh2, bh3;
  logic         core_busy;
  int           core_dly;
  logic [255:0] core_res;

  always @(posedge clk_i) begin
    if (cmp_v_o) n_vcyc <= n_vcyc + 1;
    if (rst_i) begin
      cmp_r_i      <= 1'b0;
      cmp_v_i      <= 1'b0;
      cmp_digest_i <= '0;
      core_busy    <= 1'b0;
      core_dly     <= 0;
    end else begin
      cmp_r_i <= stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (cmp_v_o && cmp_r_i) begin
        n_req <= n_req + 1;
        if (core_busy || cmp_v_i) n_overlap <= n_overlap + 1;
        if (cmp_state_o == H0) n_h0 <= n_h0 + 1;
        core_res  <= sha_compress(cmp_state_o, cmp_block_o);
        core_dly  <= stall ? int'($urandom_range(0, 4)) : 0;
        core_busy <= 1'b1;
        bh3 <= bh2; bh2 <= bh1; bh1 <= cmp_block_o;
      end else if (core_busy && !cmp_v_i) begin
        if (core_dly == 0) begin
          cmp_v_i      <= 1'b1;
          cmp_digest_i <= core_res;
          core_busy    <= 1'b0;
        end else begin
          core_dly <= core_dly - 1;
        end
      end
      if (cmp_v_i && cmp_r_o) cmp_v_i <= 1'b0;
    end
  end

  // A stalled request must stay asserted with unchanged state/block.
  logic         prev_hold = 1'b0;
  logic [767:0] prev_req;
  always @(posedge clk_i) begin
    if (prev_hold && !rst_i && !(cmp_v_o && {cmp_state_o, cmp_block_o} == prev_req))
      n_unstable <= n_unstable + 1;
    prev_hold <= cmp_v_o && !cmp_r_i && !rst_i;
    prev_req  <= {cmp_state_o, cmp_block_o};
  end

  task automatic start_req(input logic [511:0] k, input logic [1023:0] m, input int len, input bit reuse);
    int t = 0;
    while (!r_o && t < 200) begin @(negedge clk_i); t++; end
    check("ready", r_o, 1);
    key_i = k; msg_i = m; msg_len_i = LEN_W'(len); reuse_key_i = reuse; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    // scramble inputs: the DUT must have captured them at accept
    key_i = ~k; msg_i = ~m; msg_len_i = '0; reuse_key_i = ~reuse;
  endtask

  task automatic run_req(input logic [511:0] k, input logic [1023:0] m, input int len, input bit reuse,
                         input int hold, output logic [255:0] prf, output bit err, output int nc);
    int base, t, bad;
    base = n_req;
    start_req(k, m, len, reuse);
    t = 0;
    while (!v_o && t < 5000) begin @(negedge clk_i); t++; end
    check("done", v_o, 1);
    prf = prf_o; err = err_o; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!v_o || prf_o !== prf || err_o !== err) bad++;
    end
    check("hold", bad, 0);
    r_i = 1'b1;
    @(negedge clk_i);
    r_i = 1'b0;
    check("v_fall", v_o, 0);
    nc = n_req - base;
  endtask

  initial begin
    logic [255:0]  prf;
    logic [511:0]  k;
    logic [1023:0] m;
    bit            err;
    int            nc, h0b, vb, base, t;
    int            lens [3] = '{55, 56, 119};
    int            nbs  [3] = '{1, 2, 2};
    logic [63:0]   lfs  [3] = '{64'h3b8, 64'h3c0, 64'h5b8};

    rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0; key_i = '0; msg_i = '0; msg_len_i = '0; reuse_key_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_r", r_o, 0);
    check("rst_v", v_o, 0);
    check("rst_cmp_v", cmp_v_o, 0);
    check("rst_cmp_r", cmp_r_o, 0);
    check("rst_prf", prf_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", r_o, 1);

    // RFC 4231 case 2, full run
    h0b = n_h0;
    run_req(JEFE_KEY, JEFE_MSG, 28, 1'b0, 0, prf, err, nc);
    check("t1_prf", prf, JEFE_PRF);
    check("t1_err", err, 0);
    check("t1_ncmp", nc, 4);
    check("t1_h0", n_h0 - h0b, 2);

    // same key from cached midstates
    h0b = n_h0;
    run_req(JEFE_KEY, JEFE_MSG, 28, 1'b1, 0, prf, err, nc);
    check("t2_prf", prf, JEFE_PRF);
    check("t2_ncmp", nc, 2);
    check("t2_h0", n_h0 - h0b, 0);

    // block-boundary lengths with random key/message
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 16; j++) k[32*j +: 32] = $urandom;
      for (int j = 0; j < 32; j++) m[32*j +: 32] = $urandom;
      run_req(k, m, lens[i], 1'b0, 0, prf, err, nc);
      check("t3_prf", prf, hmac_ref(k, m, lens[i]));
      check("t3_err", err, 0);
      check("t3_ncmp", nc, 3 + nbs[i]);
      check("t3_lenfield", bh2[63:0], lfs[i]);
      if (lens[i] == 56) check("t3_pad80", bh3[63:56], 8'h80);
    end

    // over-length: error with no compression, even with a valid cache
    vb = n_vcyc;
    run_req(JEFE_KEY, JEFE_MSG, 120, 1'b1, 0, prf, err, nc);
    check("t4_err", err, 1);
    check("t4_prf", prf, 0);
    check("t4_ncmp", nc, 0);
    check("t4_cmp_v", n_vcyc - vb, 0);
    run_req(JEFE_KEY, JEFE_MSG, 28, 1'b0, 0, prf, err, nc);
    check("t4_next_prf", prf, JEFE_PRF);
    check("t4_next_err", err, 0);
    check("t4_next_ncmp", nc, 4);

    // random core stalls and a slow consumer
    stall = 1'b1;
    for (int j = 0; j < 16; j++) k[32*j +: 32] = $urandom;
    for (int j = 0; j < 32; j++) m[32*j +: 32] = $urandom;
    run_req(k, m, 100, 1'b0, 10, prf, err, nc);
    check("t5_prf", prf, hmac_ref(k, m, 100));
    check("t5_ncmp", nc, 5);
    stall = 1'b0;

    // reset while the first message block is outstanding
    base = n_req;
    start_req(JEFE_KEY, JEFE_MSG, 28, 1'b0);
    t = 0;
    while (n_req - base < 3 && t < 500) begin @(negedge clk_i); t++; end
    check("t6_in_msg", n_req - base, 3);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6_rst_r", r_o, 0);
    check("t6_rst_cmp_v", cmp_v_o, 0);
    check("t6_rst_cmp_r", cmp_r_o, 0);
    check("t6_rst_v", v_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_ready", r_o, 1);
    check("t6_prf0", prf_o, 0);
    run_req(JEFE_KEY, JEFE_MSG, 28, 1'b1, 0, prf, err, nc);
    check("t6_prf", prf, JEFE_PRF);
    check("t6_ncmp", nc, 4);

    check("overlap", n_overlap, 0);
    check("stable", n_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
